// File: rtl/rx_phy_pkg.sv
// Shared RX PHY definitions: FSM encoding, frame geometry and pulse-window helpers.
// Reused by the deframer, the TX serializer and the APB RX register map.
package rx_phy_pkg;

  localparam int BIT_PERIOD_DEF   = 10000;
  localparam int PREAMBLE_LEN_DEF = 8;
  localparam int PAYLOAD_LEN_DEF  = 64;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PRE     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  function automatic int win_lo(input int period);
    return period / 2;
  endfunction

  function automatic int win_hi(input int period);
    return (3 * period) / 2;
  endfunction

endpackage

// File: rtl/rfin_sync_edge.sv
// 2-FF synchronizer plus registered rising-edge detect for the raw RF input.
// o_EVT is a one-cycle pulse 3 PCLK cycles after i_RFIN rises; no backpressure.
module rfin_sync_edge (
  input  logic i_PCLK,
  input  logic i_PRESETn,
  input  logic i_RFIN,
  output logic o_EVT
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      o_EVT  <= 1'b0;
    end else begin
      r_meta <= i_RFIN;
      r_sync <= r_meta;
      r_prev <= r_sync;
      o_EVT  <= r_sync & ~r_prev;
    end
  end

endmodule

// File: rtl/rfin_pulse_deframer.sv
// Decodes the pulse-position RF line code into PAYLOAD_LEN-bit packets after an all-ones preamble.
// o_DATA/o_PKT_REC follow the last o_SH_EN by one cycle; no backpressure, unread data is overwritten (o_OVERRUN).
module rfin_pulse_deframer
  import rx_phy_pkg::*;
#(
  parameter int BIT_PERIOD_CYC = BIT_PERIOD_DEF,
  parameter int PREAMBLE_LEN   = PREAMBLE_LEN_DEF,
  parameter int PAYLOAD_LEN    = PAYLOAD_LEN_DEF,
  parameter int CNT_W          = 15
) (
  input  logic                   i_PCLK,
  input  logic                   i_PRESETn,
  input  logic                   i_RX_EN,
  input  logic                   i_RFIN,
  input  logic                   i_ACK,
  output logic                   o_SH_EN,
  output logic                   o_BIT,
  output logic [PAYLOAD_LEN-1:0] o_DATA,
  output logic                   o_PKT_REC,
  output logic                   o_VALID,
  output logic                   o_OVERRUN,
  output logic                   o_FRAME_ERR
);

  localparam int PC_W = $clog2(PREAMBLE_LEN + 1);
  localparam int BC_W = $clog2(PAYLOAD_LEN + 1);

  localparam logic [CNT_W-1:0] LO       = CNT_W'(win_lo(BIT_PERIOD_CYC));
  localparam logic [CNT_W-1:0] HI       = CNT_W'(win_hi(BIT_PERIOD_CYC));
  // Acting one count early keeps a run of zeros at exactly one slot per decode.
  localparam logic [CNT_W-1:0] HI_M1    = CNT_W'(win_hi(BIT_PERIOD_CYC) - 1);
  localparam logic [PC_W-1:0]  PRE_LAST = PC_W'(PREAMBLE_LEN - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(PAYLOAD_LEN - 1);

  logic                   w_evt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_in_win;
  logic                   w_at_hi;

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [PC_W-1:0]        r_pre_cnt;
  logic [BC_W-1:0]        r_bit_cnt;
  logic [PAYLOAD_LEN-1:0] r_shift;
  logic                   r_done;

  rfin_sync_edge u_sync (
    .i_PCLK    (i_PCLK),
    .i_PRESETn (i_PRESETn),
    .i_RFIN    (i_RFIN),
    .o_EVT     (w_evt)
  );

  assign w_cnt_nxt = (r_cnt >= HI) ? HI : r_cnt + 1'b1;
  assign w_in_win  = (r_cnt >= LO);
  assign w_at_hi   = (r_cnt >= HI_M1);

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      r_state     <= ST_HUNT;
      r_cnt       <= '0;
      r_pre_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_done      <= 1'b0;
      o_SH_EN     <= 1'b0;
      o_BIT       <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else begin
      o_SH_EN     <= 1'b0;
      o_FRAME_ERR <= 1'b0;
      r_done      <= 1'b0;
      if (!i_RX_EN) begin
        r_state   <= ST_HUNT;
        r_cnt     <= '0;
        r_pre_cnt <= '0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ST_HUNT: begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_pre_cnt <= w_evt ? PC_W'(1) : '0;
            r_state   <= w_evt ? ST_PRE : ST_HUNT;
          end
          ST_PRE: begin
            if (w_evt && w_in_win) begin
              r_cnt     <= '0;
              r_pre_cnt <= r_pre_cnt + 1'b1;
              if (r_pre_cnt == PRE_LAST) begin
                r_state   <= ST_PAYLOAD;
                r_bit_cnt <= '0;
              end
            end else if (w_at_hi) begin
              r_state   <= ST_HUNT;
              r_cnt     <= '0;
              r_pre_cnt <= '0;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
          ST_PAYLOAD: begin
            if (w_evt && !w_in_win) begin
              o_FRAME_ERR <= 1'b1;
              r_state     <= ST_HUNT;
              r_cnt       <= '0;
            end else if (w_evt || w_at_hi) begin
              // A pulse resyncs to itself; a missing pulse references the virtual mid-slot.
              o_SH_EN   <= 1'b1;
              o_BIT     <= w_evt;
              r_shift   <= {r_shift[PAYLOAD_LEN-2:0], w_evt};
              r_cnt     <= w_evt ? '0 : LO;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == BIT_LAST) begin
                r_done  <= 1'b1;
                r_state <= ST_HUNT;
              end
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
          default: begin
            r_state <= ST_HUNT;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      o_DATA    <= '0;
      o_PKT_REC <= 1'b0;
      o_VALID   <= 1'b0;
      o_OVERRUN <= 1'b0;
    end else begin
      o_PKT_REC <= r_done;
      if (r_done) begin
        o_DATA <= r_shift;
      end
      o_VALID   <= r_done | (o_VALID & ~i_ACK);
      o_OVERRUN <= (r_done & o_VALID & ~i_ACK) | (o_OVERRUN & ~i_ACK);
    end
  end

endmodule

// File: tb/tb_rfin_pulse_deframer.sv
// Directed bench for rfin_pulse_deframer with a 100-cycle bit slot.
// Packets are built slot by slot; strobes and bits are collected by a negedge monitor.
module tb_rfin_pulse_deframer;

  localparam int T = 100;
  localparam logic [63:0] P1 = 64'h8123456789ABCD0F;
  localparam logic [63:0] P2 = 64'hF000000000000FFF;
  localparam logic [63:0] P3 = 64'hA5A50000FFFF1234;

  logic        clk;
  logic        i_PRESETn;
  logic        i_RX_EN;
  logic        i_RFIN;
  logic        i_ACK;
  logic        o_SH_EN;
  logic        o_BIT;
  logic [63:0] o_DATA;
  logic        o_PKT_REC;
  logic        o_VALID;
  logic        o_OVERRUN;
  logic        o_FRAME_ERR;

  int          n_chk = 0;
  int          n_bad = 0;
  int          sh_cnt = 0;
  int          pkt_cnt = 0;
  int          ferr_cnt = 0;
  logic [63:0] cap = '0;
  int          sh_base;
  int          pkt_base;
  int          ferr_base;

  rfin_pulse_deframer #(.BIT_PERIOD_CYC(T)) dut (
    .i_PCLK      (clk),
    .i_PRESETn   (i_PRESETn),
    .i_RX_EN     (i_RX_EN),
    .i_RFIN      (i_RFIN),
    .i_ACK       (i_ACK),
    .o_SH_EN     (o_SH_EN),
    .o_BIT       (o_BIT),
    .o_DATA      (o_DATA),
    .o_PKT_REC   (o_PKT_REC),
    .o_VALID     (o_VALID),
    .o_OVERRUN   (o_OVERRUN),
    .o_FRAME_ERR (o_FRAME_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_SH_EN) begin
      sh_cnt = sh_cnt + 1;
      cap    = {cap[62:0], o_BIT};
    end
    if (o_PKT_REC)   pkt_cnt  = pkt_cnt + 1;
    if (o_FRAME_ERR) ferr_cnt = ferr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_RFIN = 1'b0;
    end
  endtask

  // One T-cycle slot; a '1' is a 3-cycle pulse starting at offset off, dbl adds a second one 20 cycles later.
  task automatic send_slot(input bit b, input int off, input bit dbl);
    for (int k = 0; k < T; k++) begin
      @(negedge clk);
      i_RFIN = b && ((k >= off && k < off + 3) || (dbl && k >= off + 20 && k < off + 23));
    end
  endtask

  function automatic int pick_off(input bit jit);
    return jit ? int'($urandom_range(30, 10)) : 20;
  endfunction

  task automatic send_pkt(input logic [63:0] d, input int npre, input int nbits,
                          input bit jit, input int glitch_at);
    for (int i = 0; i < npre; i++) send_slot(1'b1, pick_off(jit), 1'b0);
    for (int i = 0; i < nbits; i++) send_slot(d[63-i], pick_off(jit), i == glitch_at);
  endtask

  task automatic snap();
    sh_base   = sh_cnt;
    pkt_base  = pkt_cnt;
    ferr_base = ferr_cnt;
  endtask

  task automatic ack();
    @(negedge clk);
    i_ACK = 1'b1;
    @(negedge clk);
    i_ACK = 1'b0;
  endtask

  initial begin
    i_PRESETn = 1'b0;
    i_RX_EN   = 1'b1;
    i_RFIN    = 1'b0;
    i_ACK     = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data", o_DATA, 64'h0);
    chk("rst_flags", 64'({o_SH_EN, o_BIT, o_PKT_REC, o_VALID, o_OVERRUN, o_FRAME_ERR}), 64'h0);
    i_PRESETn = 1'b1;
    idle(20);

    // Nominal packet
    snap();
    send_pkt(P1, 8, 64, 1'b0, -1);
    idle(300);
    chk("nom_sh", 64'(sh_cnt - sh_base), 64'd64);
    chk("nom_pkt", 64'(pkt_cnt - pkt_base), 64'd1);
    chk("nom_data", o_DATA, P1);
    chk("nom_bits", cap, P1);
    chk("nom_valid", 64'(o_VALID), 64'd1);
    chk("nom_ovr", 64'(o_OVERRUN), 64'd0);
    chk("nom_ferr", 64'(ferr_cnt - ferr_base), 64'd0);
    ack();
    chk("ack_valid", 64'(o_VALID), 64'd0);

    // Jittered pulses, then long zero runs
    snap();
    send_pkt(P1, 8, 64, 1'b1, -1);
    idle(300);
    chk("jit1_data", o_DATA, P1);
    chk("jit1_sh", 64'(sh_cnt - sh_base), 64'd64);
    ack();
    send_pkt(P2, 8, 64, 1'b1, -1);
    idle(300);
    chk("jit2_data", o_DATA, P2);
    chk("jit2_bits", cap, P2);
    chk("jit_ferr", 64'(ferr_cnt - ferr_base), 64'd0);
    ack();

    // Short preamble then silence
    snap();
    send_pkt(P1, 5, 0, 1'b0, -1);
    idle(200);
    chk("short_sh", 64'(sh_cnt - sh_base), 64'd0);
    chk("short_pkt", 64'(pkt_cnt - pkt_base), 64'd0);

    // Early pulse inside payload bit 10
    snap();
    send_pkt(P1, 8, 64, 1'b0, 10);
    idle(300);
    chk("glit_ferr", 64'(ferr_cnt - ferr_base), 64'd1);
    chk("glit_sh", 64'(sh_cnt - sh_base), 64'd11);
    chk("glit_pkt", 64'(pkt_cnt - pkt_base), 64'd0);
    chk("glit_valid", 64'(o_VALID), 64'd0);
    snap();
    send_pkt(P1, 8, 64, 1'b0, -1);
    idle(300);
    chk("post_glit_data", o_DATA, P1);
    chk("post_glit_pkt", 64'(pkt_cnt - pkt_base), 64'd1);
    ack();

    // Back-to-back packets without ack
    snap();
    send_pkt(P2, 8, 64, 1'b0, -1);
    send_pkt(P1, 8, 64, 1'b0, -1);
    idle(300);
    chk("b2b_pkt", 64'(pkt_cnt - pkt_base), 64'd2);
    chk("b2b_data", o_DATA, P1);
    chk("b2b_valid", 64'(o_VALID), 64'd1);
    chk("b2b_ovr", 64'(o_OVERRUN), 64'd1);
    ack();
    chk("b2b_ack_valid", 64'(o_VALID), 64'd0);
    chk("b2b_ack_ovr", 64'(o_OVERRUN), 64'd0);

    // Reset at payload bit 30
    send_pkt(P1, 8, 30, 1'b0, -1);
    @(negedge clk);
    i_PRESETn = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_data", o_DATA, 64'h0);
    chk("mid_rst_flags", 64'({o_SH_EN, o_BIT, o_PKT_REC, o_VALID, o_OVERRUN, o_FRAME_ERR}), 64'h0);
    i_PRESETn = 1'b1;
    idle(50);
    snap();
    send_pkt(P3, 8, 64, 1'b0, -1);
    idle(300);
    chk("rec_data", o_DATA, P3);
    chk("rec_pkt", 64'(pkt_cnt - pkt_base), 64'd1);
    chk("rec_sh", 64'(sh_cnt - sh_base), 64'd64);
    chk("rec_valid", 64'(o_VALID), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
